port_ring_arb: RTL and testbench

PORT_RING_ARB -- requirements
Module: port_ring_arb

---
 rtl/port_ring_arb.sv | 126 ++++++++++++
 tb/tb_port_ring_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/port_ring_arb.sv
// Ring-stop arbiter: merges ring-through traffic and local injection onto
// ring-out with packet-atomic grants and a starvation guard for local.
// PRW_PCC is the low 4 bits of each word; PCC_EOP/PCC_BADEOP mark packet end.
module port_ring_arb #(
    parameter int unsigned rdp_sz     = 64,
    parameter int unsigned starve_lim = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rin_srdy,
    input  logic [rdp_sz-1:0] rin_data,
    output logic              rin_drdy,
    input  logic              lin_srdy,
    input  logic [rdp_sz-1:0] lin_data,
    output logic              lin_drdy,
    output logic              rout_srdy,
    output logic [rdp_sz-1:0] rout_data,
    input  logic              rout_drdy,
    output logic [1:0]        owner,
    output logic [3:0]        starve_cnt
);

    localparam logic [3:0] PCC_EOP    = 4'h1;
    localparam logic [3:0] PCC_BADEOP = 4'h2;
    localparam logic [3:0] LIM        = 4'(starve_lim);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        RING  = 3'b010,
        LOCAL = 3'b100
    } state_t;

    state_t state;
    logic   sel_ring;
    logic   sel_local;
    logic   rin_eop;
    logic   lin_eop;
    logic   ring_xfer;
    logic   local_xfer;

    assign rin_eop = (rin_data[3:0] == PCC_EOP) || (rin_data[3:0] == PCC_BADEOP);
    assign lin_eop = (lin_data[3:0] == PCC_EOP) || (lin_data[3:0] == PCC_BADEOP);

    // Source selection: decided live in IDLE so the winner's first word passes with no bubble
    always_comb begin
        sel_ring  = 1'b0;
        sel_local = 1'b0;
        case (state)
            IDLE: begin
                if (rin_srdy && (!lin_srdy || (starve_cnt < LIM)))
                    sel_ring = 1'b1;
                else if (lin_srdy)
                    sel_local = 1'b1;
            end
            RING:    sel_ring  = 1'b1;
            LOCAL:   sel_local = 1'b1;
            default: ;
        endcase
    end

    // Datapath steering; reset gates the handshakes off immediately
    always_comb begin
        rout_srdy = 1'b0;
        rout_data = '0;
        rin_drdy  = 1'b0;
        lin_drdy  = 1'b0;
        if (reset) begin
            if (sel_ring) begin
                rout_srdy = rin_srdy;
                rin_drdy  = rout_drdy;
                if (rin_srdy)
                    rout_data = rin_data;
            end else if (sel_local) begin
                rout_srdy = lin_srdy;
                lin_drdy  = rout_drdy;
                if (lin_srdy)
                    rout_data = lin_data;
            end
        end
    end

    assign ring_xfer  = sel_ring  && rin_srdy && rout_drdy;
    assign local_xfer = sel_local && lin_srdy && rout_drdy;

    // Grant state and local-starvation counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ring_xfer) begin
                        if (!rin_eop)
                            state <= RING;
                        if (lin_srdy && (starve_cnt < LIM))
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (local_xfer) begin
                        if (!lin_eop)
                            state <= LOCAL;
                        starve_cnt <= '0;
                    end
                end
                RING: begin
                    if (ring_xfer && rin_eop)
                        state <= IDLE;
                end
                LOCAL: begin
                    if (local_xfer && lin_eop)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Owner is a pure decode of the state register
    always_comb begin
        case (state)
            RING:    owner = 2'd1;
            LOCAL:   owner = 2'd2;
            default: owner = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_port_ring_arb.sv
// Directed bench for port_ring_arb with hand-computed expectations.
module tb_port_ring_arb;

    localparam int unsigned W = 16;
    localparam logic [3:0] C_MID    = 4'h0;
    localparam logic [3:0] C_EOP    = 4'h1;
    localparam logic [3:0] C_BADEOP = 4'h2;

    logic         clk;
    logic         reset;
    logic         rin_srdy;
    logic [W-1:0] rin_data;
    logic         rin_drdy;
    logic         lin_srdy;
    logic [W-1:0] lin_data;
    logic         lin_drdy;
    logic         rout_srdy;
    logic [W-1:0] rout_data;
    logic         rout_drdy;
    logic [1:0]   owner;
    logic [3:0]   starve_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int xfers    = 0;

    port_ring_arb #(.rdp_sz(W), .starve_lim(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .rin_srdy   (rin_srdy),
        .rin_data   (rin_data),
        .rin_drdy   (rin_drdy),
        .lin_srdy   (lin_srdy),
        .lin_data   (lin_data),
        .lin_drdy   (lin_drdy),
        .rout_srdy  (rout_srdy),
        .rout_data  (rout_data),
        .rout_drdy  (rout_drdy),
        .owner      (owner),
        .starve_cnt (starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (reset && rout_srdy && rout_drdy)
            xfers <= xfers + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [11:0] tag, input logic [3:0] pcc);
        return {tag, pcc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rin_srdy  = 1'b0;
        lin_srdy  = 1'b0;
        rin_data  = '0;
        lin_data  = '0;
        rout_drdy = 1'b1;
        reset     = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        logic [W-1:0] exp_w;
        int           rw;
        int           lw;
        int           x0;
        logic         exp_ring [8];
        logic [3:0]   exp_cnt [8];

        exp_ring = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_cnt  = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

        // Reset state, outputs forced low even with a valid source
        rin_srdy  = 1'b1;
        lin_srdy  = 1'b0;
        rin_data  = mk(12'h111, C_MID);
        lin_data  = '0;
        rout_drdy = 1'b1;
        reset     = 1'b0;
        #2;
        chk("rst_rout_srdy", 32'(rout_srdy), 32'd0);
        chk("rst_rin_drdy", 32'(rin_drdy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_starve", 32'(starve_cnt), 32'd0);

        // Idle with no source valid
        do_reset();
        #1;
        chk("idle_rout_srdy", 32'(rout_srdy), 32'd0);
        chk("idle_rout_data", 32'(rout_data), 32'd0);
        chk("idle_lin_drdy", 32'(lin_drdy), 32'd0);

        // Ring-only 4-word packet
        rin_srdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rin_data = mk(12'hA00 + 12'(i), (i == 3) ? C_EOP : C_MID);
            #1;
            chk("r4_srdy", 32'(rout_srdy), 32'd1);
            chk("r4_data", 32'(rout_data), 32'(rin_data));
            chk("r4_drdy", 32'(rin_drdy), 32'd1);
            chk("r4_owner", 32'(owner), (i == 0) ? 32'd0 : 32'd1);
            step();
        end
        rin_srdy = 1'b0;
        #1;
        chk("r4_owner_end", 32'(owner), 32'd0);

        // Both continuously valid, 2-word packets, starvation rotation
        do_reset();
        rw = 0;
        lw = 0;
        rin_srdy = 1'b1;
        lin_srdy = 1'b1;
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < 2; k++) begin
                rin_data = mk(12'hB00 + 12'(rw), rw[0] ? C_EOP : C_MID);
                lin_data = mk(12'hC00 + 12'(lw), lw[0] ? C_EOP : C_MID);
                exp_w = exp_ring[p] ? rin_data : lin_data;
                #1;
                chk("rot_rin_drdy", 32'(rin_drdy), 32'(exp_ring[p]));
                chk("rot_lin_drdy", 32'(lin_drdy), 32'(!exp_ring[p]));
                chk("rot_data", 32'(rout_data), 32'(exp_w));
                if (k == 1)
                    chk("rot_owner", 32'(owner), exp_ring[p] ? 32'd1 : 32'd2);
                step();
                if (exp_ring[p]) rw++; else lw++;
                if (k == 0)
                    chk("rot_starve", 32'(starve_cnt), 32'(exp_cnt[p]));
            end
        end

        // Local-only single-word packets, EOP and BADEOP
        do_reset();
        rin_srdy = 1'b0;
        lin_srdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lin_data = mk(12'hD00 + 12'(i), i[0] ? C_BADEOP : C_EOP);
            #1;
            chk("l1_drdy", 32'(lin_drdy), 32'd1);
            chk("l1_owner", 32'(owner), 32'd0);
            chk("l1_data", 32'(rout_data), 32'(lin_data));
            step();
        end

        // Local source stalls mid-packet while ring waits
        do_reset();
        lin_srdy = 1'b1;
        lin_data = mk(12'hE00, C_MID);
        #1;
        chk("ls_first", 32'(lin_drdy), 32'd1);
        step();
        lin_srdy = 1'b0;
        rin_srdy = 1'b1;
        rin_data = mk(12'hE80, C_EOP);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ls_rout_srdy", 32'(rout_srdy), 32'd0);
            chk("ls_rout_data", 32'(rout_data), 32'd0);
            chk("ls_rin_drdy", 32'(rin_drdy), 32'd0);
            chk("ls_owner", 32'(owner), 32'd2);
            step();
        end
        lin_srdy = 1'b1;
        lin_data = mk(12'hE01, C_EOP);
        #1;
        chk("ls_last_drdy", 32'(lin_drdy), 32'd1);
        chk("ls_last_data", 32'(rout_data), 32'(lin_data));
        chk("ls_last_rin", 32'(rin_drdy), 32'd0);
        step();
        #1;
        chk("ls_after_owner", 32'(owner), 32'd0);
        chk("ls_after_ring", 32'(rin_drdy), 32'd1);

        // Downstream backpressure during a ring packet
        do_reset();
        x0 = xfers;
        rin_srdy = 1'b1;
        rin_data = mk(12'hF00, C_MID);
        #1;
        chk("bp_first", 32'(rin_drdy), 32'd1);
        step();
        rin_data  = mk(12'hF01, C_MID);
        rout_drdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rin_drdy", 32'(rin_drdy), 32'd0);
            chk("bp_srdy", 32'(rout_srdy), 32'd1);
            chk("bp_data", 32'(rout_data), 32'(mk(12'hF01, C_MID)));
            step();
        end
        rout_drdy = 1'b1;
        #1;
        chk("bp_resume", 32'(rin_drdy), 32'd1);
        step();
        rin_data = mk(12'hF02, C_EOP);
        #1;
        chk("bp_eop_data", 32'(rout_data), 32'(mk(12'hF02, C_EOP)));
        step();
        rin_srdy = 1'b0;
        #1;
        chk("bp_owner_end", 32'(owner), 32'd0);
        chk("bp_xfers", 32'(xfers - x0), 32'd3);

        // Asynchronous reset in the middle of a local packet
        do_reset();
        lin_srdy = 1'b1;
        lin_data = mk(12'h900, C_MID);
        step();
        rin_srdy = 1'b1;
        rin_data = mk(12'h980, C_MID);
        lin_data = mk(12'h901, C_MID);
        #1;
        chk("ar_owner_pre", 32'(owner), 32'd2);
        reset = 1'b0;
        #1;
        chk("ar_rout_srdy", 32'(rout_srdy), 32'd0);
        chk("ar_lin_drdy", 32'(lin_drdy), 32'd0);
        chk("ar_owner", 32'(owner), 32'd0);
        chk("ar_starve", 32'(starve_cnt), 32'd0);
        #1;
        reset = 1'b1;
        step();
        chk("ar_restart_owner", 32'(owner), 32'd1);
        chk("ar_restart_starve", 32'(starve_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
